// File: rtl/serial_rx_if.sv
// Serial receiver bus: the line into the receiver and the recovered byte,
// strobes and status coming back out of it.
interface serial_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  // Line driver / byte consumer side
  modport master (
    output rx,
    input  data_out,
    input  valid,
    input  frame_err,
    input  busy
  );

  // Receiver side
  modport slave (
    input  rx,
    output data_out,
    output valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/serial_rx.sv
// 8N1 serial receiver. Oversamples the line at CLKS_PER_BIT clocks per bit,
// recovers each byte LSB first, strobes valid on a good stop bit and
// frame_err on a low stop bit. A line held low after a framing error is
// parked in BREAK until it returns high.
module serial_rx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_rx_if.slave  bus
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             rx_p0, rx_p1;
  logic             rx_s;

  // Two-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= bus.rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // Next-state logic: bit timing is measured from t0, the first edge in
  // IDLE that sees the line low; every later sample lands mid-bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            // Low pulse shorter than half a bit: treat as a glitch
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            // Leaving at mid-stop keeps half a bit of slack for the next start
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control, output and timing registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Shift register holds only in-flight data bits; no reset needed
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: a behavioural 8N1 line driver feeds the receiver,
// expected strobes go into a scoreboard queue, and a monitor pops and
// compares them whenever valid or frame_err shows up.
module tb_serial_rx;

  localparam int CPB = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  logic [7:0] last_good;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];

  serial_rx_if bus ();

  serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // One frame; stop_b=0 forces a framing error. Must be entered #1 after a posedge.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    exp_t e;
    e.is_err = !stop_b;
    e.data   = stop_b ? d : last_good;
    e.cyc    = cyc + 79;
    sb_q.push_back(e);
    if (stop_b) last_good = d;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_b);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.valid || bus.frame_err) begin
        chk("valid_and_ferr_exclusive", int'(bus.valid & bus.frame_err), 0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data_out=%0h cyc %0d",
                   bus.valid, bus.frame_err, bus.data_out, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("strobe_kind_ferr", int'(bus.frame_err), int'(e.is_err));
          chk("strobe_cycle", cyc, e.cyc);
          chk("data_out", int'(bus.data_out), int'(e.data));
        end
      end
    end
  endtask

  initial begin
    int n0;
    checks    = 0;
    errors    = 0;
    last_good = 8'h00;
    bus.rx    = 1'b1;
    rst       = 1'b0;
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data_out", int'(bus.data_out), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_frame_err", int'(bus.frame_err), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;

    // A5 single frame
    send_frame(8'hA5, 1'b1);
    repeat (4 * CPB) @(posedge clk); #1;

    // Reset pulse, then 3C with busy window checks
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_data_out", int'(bus.data_out), 0);
    @(posedge clk); #1;
    rst       = 1'b1;
    last_good = 8'h00;
    repeat (3) @(posedge clk); #1;
    fork
      send_frame(8'h3C, 1'b1);
      begin
        n0 = cyc;
        wait_cyc(n0 + 2);  chk("busy_before_t0", int'(bus.busy), 0);
        wait_cyc(n0 + 3);  chk("busy_at_t0", int'(bus.busy), 1);
        wait_cyc(n0 + 78); chk("busy_before_stop", int'(bus.busy), 1);
        wait_cyc(n0 + 80); chk("busy_after_stop", int'(bus.busy), 0);
      end
    join
    repeat (2 * CPB) @(posedge clk); #1;

    // Two-cycle glitch
    n0     = cyc;
    bus.rx = 1'b0;
    repeat (2) @(posedge clk); #1;
    bus.rx = 1'b1;
    wait_cyc(n0 + 3); chk("glitch_busy_t0", int'(bus.busy), 1);
    wait_cyc(n0 + 7); chk("glitch_busy_idle", int'(bus.busy), 0);
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_data_out", int'(bus.data_out), 8'h3C);
    @(posedge clk); #1;

    // 55 with low stop bit, then line held low for 20 bit times
    n0 = cyc;
    send_frame(8'h55, 1'b0);
    bus.rx = 1'b0;
    repeat (20 * CPB) @(posedge clk); #1;
    chk("break_busy", int'(bus.busy), 1);
    chk("break_data_out", int'(bus.data_out), 8'h3C);
    n0 = cyc;
    bus.rx = 1'b1;
    wait_cyc(n0 + 5); chk("break_released_busy", int'(bus.busy), 0);
    repeat (2 * CPB) @(posedge clk); #1;

    // Abort FF after data bit 3 with reset, then 0F
    bus.rx = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rst    = 1'b0;
    bus.rx = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_valid", int'(bus.valid), 0);
    chk("abort_data_out", int'(bus.data_out), 0);
    repeat (3) @(posedge clk); #1;
    rst       = 1'b1;
    last_good = 8'h00;
    repeat (6 * CPB) @(posedge clk); #1;
    chk("abort_idle_busy", int'(bus.busy), 0);
    send_frame(8'h0F, 1'b1);
    repeat (2 * CPB) @(posedge clk); #1;

    // Back-to-back frames
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    repeat (4 * CPB) @(posedge clk); #1;

    chk("final_data_out", int'(bus.data_out), 8'h80);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #500000;
    $display("FAIL timeout: cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
UART-style 8N1 receiver that sits directly downstream of serial_tx and consumes its tx line. It oversamples the line at CLKS_PER_BIT clocks per bit and recovers each 8-bit byte, LSB first. It presents the byte with a one-cycle valid strobe and flags framing errors. In loopback benches it connects rx to serial_tx.tx, with the same CLKS_PER_BIT.

Parameters:
CLKS_PER_BIT, 8, clock cycles per serial bit. Must be >= 4. HALF = CLKS_PER_BIT/2 (integer division).

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  one clock; reset is asynchronous and active-low
rx  input  1  serial line, idle high, asynchronous to clk
data_out  output  8  last correctly received byte
valid  output  1  one-cycle pulse: data_out was just updated
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high while a frame is being received

Behaviour:
- Reset (rst=0, async): data_out=8'h00, valid=0, frame_err=0, busy=0; both synchronizer flops=1; state=IDLE; counters=0.
- Input sync: rx passes through 2 flops to give rx_s. All logic below uses only rx_s.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - The first rising edge that sees rx_s=0 is t0.
  - At t0: go to START, clear the bit counter, set busy=1 (visible after t0).
- START:
  - At edge t0+HALF, sample rx_s.
  - If 0: go to DATA.
  - If 1: glitch. Return to IDLE, busy=0, no pulses.
- DATA:
  - Data bit k (k=0..7) is sampled at edge t0+HALF+(k+1)*CLKS_PER_BIT and shifted into bit k of a shift register (LSB first).
  - After bit 7, go to STOP.
- STOP:
  - Sample at edge ts = t0+HALF+9*CLKS_PER_BIT.
  - If 1: at ts, load data_out from the shift register and set valid=1 for exactly one cycle. Go to IDLE, busy=0.
  - If 0: set frame_err=1 for exactly one cycle. data_out is unchanged. Go to BREAK, busy stays 1.
- BREAK: wait for rx_s=1, then go to IDLE and set busy=0. A held-low line never produces spurious frames.
- Timing:
  - t0 is the 3rd rising edge after rx falls (2 sync flops).
  - With CLKS_PER_BIT=8: mid-start check at t0+4; bit0 at t0+12; stop sample at t0+76.
  - valid is high during the cycle after edge t0+76.
- valid and frame_err are never high in the same cycle. Neither is asserted outside STOP exit.
- Back-to-back frames: a start bit that begins right after the stop bit is detected. The IDLE return at mid-stop leaves half a bit of margin.
- data_out holds its value between frames. It changes only when valid is pulsed.
- Reset mid-frame: everything returns to reset values immediately. The partial byte is discarded and there are no pulses. After release, reception restarts only on a new falling edge.
- Counters must be wide enough for CLKS_PER_BIT-1 (clog2) plus a 3-bit bit index. No counter wraps inside a frame.

Test Plan:
- Loopback with serial_tx, CLKS_PER_BIT=8, send 8'hA5 -> exactly one valid pulse, 76 cycles after t0; data_out=8'hA5; frame_err never high.
- Reset via rst, then send 8'h3C -> data_out=8'h3C, one valid pulse; busy high from t0+1 until the cycle after the stop sample.
- Drive rx low for 2 clk cycles only, then high -> busy pulses briefly, returns to IDLE by t0+4; no valid or frame_err; data_out unchanged.
- Hand-driven frame 8'h55 with stop bit forced low, then rx held low for 20 bit times, then high -> a single frame_err pulse at t0+76; data_out unchanged; no further frames until rx returns high.
- Assert rst after bit 3 of a frame for 8'hFF, release, then send 8'h0F -> no pulse for the aborted frame; data_out=8'h0F after the second frame.
- Two consecutive serial_tx frames 8'h01 then 8'h80 with minimum gap -> two valid pulses, data_out=8'h01 then 8'h80.
